// File: rtl/logic_ops_pkg.sv
// Shared opcode constants, FSM state encoding and opcode validity helper
// for the bit-serial logic engine and the parallel gate wrappers.
package logic_ops_pkg;

   localparam logic [2:0] OP_NOT  = 3'd0;
   localparam logic [2:0] OP_AND  = 3'd1;
   localparam logic [2:0] OP_OR   = 3'd2;
   localparam logic [2:0] OP_NAND = 3'd3;
   localparam logic [2:0] OP_NOR  = 3'd4;
   localparam logic [2:0] OP_XOR  = 3'd5;
   localparam logic [2:0] OP_XNOR = 3'd6;
   localparam logic [2:0] OP_MAX  = 3'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic op_is_valid(input logic [2:0] op);
      return (op <= OP_MAX);
   endfunction

endpackage

// File: rtl/logic_bit_cell.sv
// Single-bit gate cell: evaluates one opcode on one bit pair.
// Invalid opcodes produce 0.
module logic_bit_cell
   import logic_ops_pkg::*;
(
   input  logic [2:0] op,
   input  logic       a,
   input  logic       b,
   output logic       y
);

   // combinational gate select
   always_comb begin
      y = 1'b0;
      case (op)
         OP_NOT:  y = ~a;
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         default: y = 1'b0;
      endcase
   end

endmodule

// File: rtl/logic_serial_engine.sv
// Bit-serial logic engine: accepts one command, evaluates it LSB first
// through a single bit cell, then presents the packed result.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// BUSY  | shifting operands through the cell, one bit per cycle
// DONE  | result held on res_* until the consumer takes it
module logic_serial_engine
   import logic_ops_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_in1,
   input  logic [WIDTH-1:0] cmd_in2,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_zero,
   output logic             res_err
);

   generate
      if (WIDTH < 1) begin : g_bad_width
         $error("logic_serial_engine: WIDTH must be >= 1");
      end
   endgenerate

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             zero_q, zero_d;
   logic             err_q, err_d;
   logic             cell_y;

   logic_bit_cell u_cell (
      .op (op_q),
      .a  (a_q[0]),
      .b  (b_q[0]),
      .y  (cell_y)
   );

   // next-state and datapath update
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               if (op_is_valid(cmd_op)) begin
                  op_d    = cmd_op;
                  a_d     = cmd_in1;
                  b_d     = cmd_in2;
                  res_d   = '0;
                  cnt_d   = '0;
                  zero_d  = 1'b0;
                  err_d   = 1'b0;
                  state_d = BUSY;
               end else begin
                  res_d   = '0;
                  zero_d  = 1'b1;
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         BUSY: begin
            // new bit enters at the MSB so bit 0 lands in place after WIDTH shifts
            res_d = (res_q >> 1) | (WIDTH'(cell_y) << (WIDTH - 1));
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               zero_d  = (res_d == '0);
               state_d = DONE;
            end
         end
         DONE: begin
            if (res_ready) begin
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
         err_q   <= err_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign res_valid = (state_q == DONE);
   assign res_data  = res_q;
   assign res_zero  = zero_q;
   assign res_err   = err_q;

endmodule
